// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall masks,
// exception codes, the default handler vector and the controller state encoding.
package pipeline_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DEFER = 1'b1
  } state_e;

  // eret returns to EPC; every other exception enters the common handler.
  function automatic logic [31:0] exc_target(input logic [31:0] code,
                                             input logic [31:0] epc,
                                             input logic [31:0] vector);
    return (code == EXC_ERET) ? epc : vector;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// Stall statistics: saturating stall-cycle counter and a sticky watchdog that
// trips after WDT_LIMIT consecutive stalled cycles.
module stall_watchdog #(
  parameter int unsigned WDT_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stalled,
  output logic [31:0] stall_cycles,
  output logic        wdt_timeout
);

  localparam int RUN_W = $clog2(WDT_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WDT_LIMIT);

  logic [31:0]      stall_cycles_q, stall_cycles_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             wdt_timeout_q, wdt_timeout_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    run_len_d      = '0;
    wdt_timeout_d  = wdt_timeout_q;
    if (stalled) begin
      if (stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
      // run_len parks at the limit so it cannot wrap during an endless stall.
      run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + 1'b1;
    end
    if (run_len_d == RUN_MAX) wdt_timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      run_len_q      <= '0;
      wdt_timeout_q  <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      run_len_q      <= run_len_d;
      wdt_timeout_q  <= wdt_timeout_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign wdt_timeout  = wdt_timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: arbitrates stage stall requests, sequences
// exception/eret flushes (deferring them while MEM waits on the bus).
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int unsigned WDT_LIMIT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        wdt_timeout,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  logic [31:0] pend_type_q, pend_type_d;
  logic [31:0] pend_epc_q, pend_epc_d;
  logic [5:0]  req_mask;

  always_comb begin
    if (stallreq_mem)     req_mask = STALL_MEM;
    else if (stallreq_ex) req_mask = STALL_EX;
    else if (stallreq_id) req_mask = STALL_ID;
    else                  req_mask = STALL_NONE;
  end

  always_comb begin
    state_d     = state_q;
    pend_type_d = pend_type_q;
    pend_epc_d  = pend_epc_q;
    stall       = STALL_NONE;
    flush       = 1'b0;
    new_pc      = 32'h0;
    case (state_q)
      ST_RUN: begin
        if (excepttype != EXC_NONE) begin
          if (stallreq_mem) begin
            // Bus still busy: hold the exception until MEM can be cleared.
            pend_type_d = excepttype;
            pend_epc_d  = cp0_epc;
            stall       = STALL_MEM;
            state_d     = ST_DEFER;
          end else begin
            flush  = 1'b1;
            new_pc = exc_target(excepttype, cp0_epc, EXC_VECTOR);
          end
        end else begin
          stall = req_mask;
        end
      end
      ST_DEFER: begin
        if (stallreq_mem) begin
          stall = STALL_MEM;
        end else begin
          flush   = 1'b1;
          new_pc  = exc_target(pend_type_q, pend_epc_q, EXC_VECTOR);
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pend_type_q <= 32'h0;
      pend_epc_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pend_type_q <= pend_type_d;
      pend_epc_q  <= pend_epc_d;
    end
  end

  assign dbg_state = state_q;

  stall_watchdog #(
    .WDT_LIMIT (WDT_LIMIT)
  ) u_wdt (
    .clk          (clk),
    .rst          (rst),
    .stalled      (stall != STALL_NONE),
    .stall_cycles (stall_cycles),
    .wdt_timeout  (wdt_timeout)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stall priority, RUN/DEFER flushes,
// reset during DEFER, watchdog and stall counter saturation.
import pipeline_ctrl_pkg::*;

module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        wdt_timeout;
  state_e      dbg_state;

  int vectors;
  int miscompares;

  pipeline_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .WDT_LIMIT  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype   (excepttype),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_cycles (stall_cycles),
    .wdt_timeout  (wdt_timeout),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: new inputs just after the falling edge, outputs checked 1ns later
  task automatic drive(input logic r, input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc);
    @(negedge clk);
    rst          = r;
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excepttype   = exc;
    cp0_epc      = epc;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                         input logic [31:0] e_pc);
    chk({tag, ".stall"}, {26'h0, stall}, {26'h0, e_stall});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, e_flush});
    chk({tag, ".new_pc"}, new_pc, e_pc);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    excepttype = 32'h0; cp0_epc = 32'h0;

    // Reset with every request and an exception present: outputs forced to 0.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h1234);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h1234);
    chk_out("rst_force", 6'b000000, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_cycles", stall_cycles, 32'h0);
    chk("rst_wdt", {31'h0, wdt_timeout}, 32'h0);
    chk("rst_state", {31'h0, dbg_state}, {31'h0, ST_RUN});
    chk_out("idle", 6'b000000, 1'b0, 32'h0);

    // Watchdog (limit 4): run of 3, gap, run of 4.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      chk("wdt_run1_stall", {26'h0, stall}, {26'h0, 6'b001111});
      chk("wdt_run1", {31'h0, wdt_timeout}, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wdt_gap", {31'h0, wdt_timeout}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      chk("wdt_run2", {31'h0, wdt_timeout}, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wdt_trip", {31'h0, wdt_timeout}, 32'h1);
    chk("wdt_cycles", stall_cycles, 32'd7);
    chk_out("wdt_no_effect", 6'b000000, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wdt_sticky", {31'h0, wdt_timeout}, 32'h1);

    // Fresh reset for the remaining scenarios.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst2_wdt", {31'h0, wdt_timeout}, 32'h0);
    chk("rst2_cycles", stall_cycles, 32'h0);

    // ID+EX for 3 cycles: EX mask wins, counter 0->3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      chk_out("id_ex", 6'b001111, 1'b0, 32'h0);
      chk("id_ex_cycles", stall_cycles, 32'(i));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("id_ex_total", stall_cycles, 32'd3);

    // Priority table.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
    chk_out("prio_mem", 6'b011111, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_out("prio_id", 6'b000111, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk_out("prio_ex", 6'b001111, 1'b0, 32'h0);

    // RUN-path exception, flush dominates pending ID/EX requests.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h7777);
    chk_out("exc_run", 6'b000000, 1'b1, 32'h0000_0020);
    chk("exc_run_cycles", stall_cycles, 32'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h7777);
    chk_out("exc_run_after", 6'b000000, 1'b0, 32'h0);
    chk("flush_not_counted", stall_cycles, 32'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'h0000_1234);
    chk_out("eret_run", 6'b000000, 1'b1, 32'h0000_1234);

    // eret deferred behind a 4-cycle bus wait.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'he, 32'h0000_1000);
      chk_out("defer_wait", 6'b011111, 1'b0, 32'h0);
    end
    chk("defer_state", {31'h0, dbg_state}, {31'h0, ST_DEFER});
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_5555);
    chk_out("defer_exit", 6'b000000, 1'b1, 32'h0000_1000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_out("defer_after", 6'b000000, 1'b0, 32'h0);
    chk("defer_back_run", {31'h0, dbg_state}, {31'h0, ST_RUN});

    // Deferred syscall; inputs changing during DEFER are ignored.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0000_4444);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'he, 32'h0000_9999);
    chk_out("defer2_wait", 6'b011111, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'h0000_9999);
    chk_out("defer2_exit", 6'b000000, 1'b1, 32'h0000_0020);

    // Reset while in DEFER drops the pending exception.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hc, 32'h0000_3333);
    chk_out("defer3_enter", 6'b011111, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk_out("defer3_rst", 6'b000000, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_out("defer3_no_flush", 6'b000000, 1'b0, 32'h0);
    chk("defer3_state", {31'h0, dbg_state}, {31'h0, ST_RUN});
    chk("defer3_cycles", stall_cycles, 32'h0);

    // Counter saturation from a preloaded value.
    @(negedge clk);
    force dut.u_wdt.stall_cycles_q = 32'hFFFF_FFFD;
    #1;
    release dut.u_wdt.stall_cycles_q;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("sat_0", stall_cycles, 32'hFFFF_FFFD);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("sat_1", stall_cycles, 32'hFFFF_FFFE);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("sat_2", stall_cycles, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It arbitrates stall requests from ID, EX and MEM into the per-stage `stall[5:0]` vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb). It sequences exception and eret flushes, computing the redirect PC. An exception raised while MEM waits on the bus is deferred until the bus transaction completes. It also keeps a stall-cycle performance counter and a stall watchdog.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0020, handler entry PC for all non-eret exceptions
- WDT_LIMIT, 1024, consecutive stall cycles that trip the watchdog (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- stallreq_id  in  1  ID stall request (load-use)
- stallreq_ex  in  1  EX stall request (multi-cycle mul/div)
- stallreq_mem  in  1  MEM stall request (data bus wait)
- excepttype  in  32  exception code from MEM stage; 0 = none
- cp0_epc  in  32  EPC value for eret
- stall  out  6  per-stage hold: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
- flush  out  1  clear all pipeline registers and load new_pc
- new_pc  out  32  redirect target, valid when flush=1
- stall_cycles  out  32  saturating count of cycles with stall≠0
- wdt_timeout  out  1  sticky watchdog flag

## Operation
- Stall masks, priority MEM > EX > ID: stallreq_mem → 6'b011111; else stallreq_ex → 6'b001111; else stallreq_id → 6'b000111; else 6'b000000.
- Exception target: excepttype 32'h0000_000e (eret) → cp0_epc. Any other nonzero code (1 int, 8 syscall, a invalid, c overflow, d trap) → EXC_VECTOR.
- FSM states:
  - RUN, excepttype≠0, stallreq_mem=0: flush=1 combinationally this cycle, new_pc per target rule, stall=0; stay in RUN.
  - RUN, excepttype≠0, stallreq_mem=1: latch excepttype into pend_type and cp0_epc into pend_epc; flush=0, stall=011111; go to DEFER.
  - RUN, no exception: flush=0, stall per masks.
  - DEFER, stallreq_mem=1: stall=011111, flush=0. Inputs excepttype and cp0_epc are ignored.
  - DEFER, stallreq_mem=0: flush=1, new_pc from pend_type/pend_epc, stall=0; go to RUN.
- Flush dominates: whenever flush=1, stall=0, whatever the requests.
- new_pc=0 whenever flush=0.
- stall_cycles increments on every cycle with stall≠0 and saturates at 32'hFFFF_FFFF.
- Watchdog: run_len counts consecutive cycles with stall≠0 and clears on any cycle with stall=0. wdt_timeout sets when run_len reaches WDT_LIMIT and stays set until rst. The watchdog never alters stall or flush.

## Timing
- Reset: synchronous. State=RUN; pend_type, pend_epc, run_len, stall_cycles = 0; wdt_timeout=0. While rst=1, stall, flush and new_pc are forced to 0.
- stall, flush and new_pc are combinational from inputs plus state, with zero latency. Pipeline registers sample them at the same clock edge.
- Flush pulse width:
  - RUN path: exactly one cycle per cycle the exception is presented (MEM clears after flush, so normally one).
  - DEFER path: exactly one cycle, in the first cycle stallreq_mem is low.
- DEFER exit needs no extra bubble: flush occurs in the same cycle the bus completes.
- A flush cycle counts as non-stall: it clears run_len and does not increment stall_cycles.
- rst asserted in DEFER discards the pending exception; no flush follows.

## Structure
- Shared defines include:
  - stall masks STALL_ID/STALL_EX/STALL_MEM
  - exception codes (EXC_ERET = 32'h0000_000e, etc.)
  - default EXC_VECTOR
  - state encodings ST_RUN/ST_DEFER
- Sub-module stall_watchdog: inputs clk, rst, stalled; parameter WDT_LIMIT; outputs stall_cycles and wdt_timeout.
- The top level holds the FSM, the pending registers and the combinational mask/target logic.

## Test plan
- stallreq_id=1 and stallreq_ex=1 for 3 cycles → stall=001111 each cycle, flush=0; stall_cycles goes 0→3.
- RUN, excepttype=32'h8, stallreq_mem=0 → same cycle flush=1, new_pc=32'h20, stall=000000; the next cycle with excepttype=0 has flush=0.
- excepttype=32'he, cp0_epc=32'h1000, stallreq_mem=1 for 4 cycles, then excepttype changes to 0 and cp0_epc to 32'h5555 → stall=011111 for 4 cycles, no flush; 5th cycle flush=1, new_pc=32'h1000.
- WDT_LIMIT=4: stallreq_ex high 3 cycles, low 1, high 4 → wdt_timeout stays 0 through the first run and rises after the 4th cycle of the second run; it remains 1 after requests drop.
- DEFER entered, then rst for 1 cycle, then stallreq_mem=0 → no flush; all outputs 0 during rst; state RUN afterwards.
- Preload stall_cycles near saturation (force or long run with small counter override) → holds at 32'hFFFF_FFFF, no wrap.
